ncsi_fc_req_sched: RTL and testbench



---
 rtl/ncsi_fc_req_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_ncsi_fc_req_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncsi_fc_req_sched.sv
// ncsi_fc_req_sched: round-robin scheduler for the NCSI filter-configuration mailbox.
// Scans MAX_FC_REQ pending slots, runs one 32-bit AVMM read or write per grant and
// reports a per-slot completion pulse with result data, status code and slot index.
// Optional build macro NCSI_FC_TIMEOUT_EN adds a per-command timeout (TIMEOUT_CYC, >= 2).
module ncsi_fc_req_sched #(
    parameter int unsigned MAX_FC_REQ  = 16,
    parameter int unsigned HSSI_ADDR_W = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [64*MAX_FC_REQ-1:0]  fc_ctrl_i,
    input  logic [MAX_FC_REQ-1:0]     fc_pend_i,
    output logic [MAX_FC_REQ-1:0]     fc_done_pls_o,
    output logic [31:0]               fc_rsp_data_o,
    output logic [1:0]                fc_rsp_code_o,
    output logic [6:0]                fc_rsp_slot_o,
    output logic                      fc_busy_o,
    output logic [HSSI_ADDR_W-1:0]    hssi_avmm_m_addr_o,
    output logic                      hssi_avmm_m_write_o,
    output logic                      hssi_avmm_m_read_o,
    output logic [31:0]               hssi_avmm_m_wrdata_o,
    input  logic [31:0]               hssi_avmm_m_rddata_i,
    input  logic                      hssi_avmm_m_rddvld_i,
    input  logic                      hssi_avmm_m_waitreq_i
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [6:0]             ptr_q, ptr_d;
    logic [6:0]             slot_q, slot_d;
    logic                   op_q, op_d;
    logic [HSSI_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            wrdata_q, wrdata_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic [1:0]             rsp_code_q, rsp_code_d;
    logic [6:0]             rsp_slot_q, rsp_slot_d;

    logic                   gnt_vld;
    logic [6:0]             gnt_idx;
    logic [6:0]             hi_idx, lo_idx;
    logic                   hi_vld;
    logic [63:0]            gnt_ctrl;
    logic                   tmo_expire;
    logic                   unused_ctrl;

    // Round-robin pick: lowest pending index at or above the pointer, else lowest overall
    always_comb begin
        hi_vld  = 1'b0;
        hi_idx  = '0;
        gnt_vld = 1'b0;
        lo_idx  = '0;
        for (int i = int'(MAX_FC_REQ) - 1; i >= 0; i--) begin
            if (fc_pend_i[i]) begin
                gnt_vld = 1'b1;
                lo_idx  = 7'(i);
                if (7'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = 7'(i);
                end
            end
        end
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Control word of the granted slot
    always_comb begin
        gnt_ctrl = '0;
        for (int i = 0; i < int'(MAX_FC_REQ); i++) begin
            if (gnt_idx == 7'(i)) begin
                gnt_ctrl = fc_ctrl_i[64*i +: 64];
            end
        end
    end

    // Only op, address and write data of the control word are consumed
    assign unused_ctrl = ^gnt_ctrl;

`ifdef NCSI_FC_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Timeout counter: held at zero while idle, counts while a command is outstanding
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == StIdle) begin
            tmo_cnt_d = '0;
        end else if (state_q == StIssue || state_q == StWaitRd) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Expire in the cycle whose increment would land on TIMEOUT_CYC-1, so DONE follows
    // exactly TIMEOUT_CYC cycles after the grant cycle.
    assign tmo_expire = (state_q == StIssue || state_q == StWaitRd) &&
                        (tmo_cnt_q == CntW'(TIMEOUT_CYC - 2));
`else
    assign tmo_expire = 1'b0;
`endif

    // FSM next-state, command latch and result update
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        slot_d     = slot_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        rsp_data_d = rsp_data_q;
        rsp_code_d = rsp_code_q;
        rsp_slot_d = rsp_slot_q;

        unique case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    slot_d   = gnt_idx;
                    op_d     = gnt_ctrl[48];
                    addr_d   = gnt_ctrl[32 +: HSSI_ADDR_W];
                    wrdata_d = gnt_ctrl[31:0];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (tmo_expire) begin
                    rsp_data_d = '0;
                    rsp_code_d = 2'b01;
                    rsp_slot_d = slot_q;
                    state_d    = StDone;
                end else if (!hssi_avmm_m_waitreq_i) begin
                    if (op_q) begin
                        rsp_data_d = '0;
                        rsp_code_d = 2'b00;
                        rsp_slot_d = slot_q;
                        state_d    = StDone;
                    end else begin
                        state_d = StWaitRd;
                    end
                end
            end
            StWaitRd: begin
                // A response arriving in the expiry cycle still counts as success
                if (hssi_avmm_m_rddvld_i) begin
                    rsp_data_d = hssi_avmm_m_rddata_i;
                    rsp_code_d = 2'b00;
                    rsp_slot_d = slot_q;
                    state_d    = StDone;
                end else if (tmo_expire) begin
                    rsp_data_d = '0;
                    rsp_code_d = 2'b01;
                    rsp_slot_d = slot_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                ptr_d   = (slot_q == 7'(MAX_FC_REQ - 1)) ? 7'd0 : slot_q + 7'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            slot_q     <= '0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            wrdata_q   <= '0;
            rsp_data_q <= '0;
            rsp_code_q <= '0;
            rsp_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            slot_q     <= slot_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_code_q <= rsp_code_d;
            rsp_slot_q <= rsp_slot_d;
        end
    end

    // Outputs: strobes and completion pulse are gated by reset so an aborted command
    // drops immediately and never reports completion.
    always_comb begin
        fc_busy_o            = (state_q != StIdle);
        hssi_avmm_m_write_o  = (state_q == StIssue) && op_q && !reset_i;
        hssi_avmm_m_read_o   = (state_q == StIssue) && !op_q && !reset_i;
        hssi_avmm_m_addr_o   = (state_q == StIssue) ? addr_q : '0;
        hssi_avmm_m_wrdata_o = (state_q == StIssue) ? wrdata_q : '0;
        fc_rsp_data_o        = rsp_data_q;
        fc_rsp_code_o        = rsp_code_q;
        fc_rsp_slot_o        = rsp_slot_q;
        fc_done_pls_o        = '0;
        for (int i = 0; i < int'(MAX_FC_REQ); i++) begin
            fc_done_pls_o[i] = (state_q == StDone) && !reset_i && (slot_q == 7'(i));
        end
    end

endmodule

// File: tb/tb_ncsi_fc_req_sched.sv
// Self-checking bench for ncsi_fc_req_sched: table of single transactions plus
// hand-written sequences for round-robin wrap, reset abort and timeout corners.
module tb_ncsi_fc_req_sched;

    localparam int N = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [64*N-1:0]  fc_ctrl;
    logic [N-1:0]     fc_pend;
    logic [N-1:0]     done;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_code;
    logic [6:0]       rsp_slot;
    logic             busy;
    logic [15:0]      addr;
    logic             wr, rd;
    logic [31:0]      wrdata;
    logic [31:0]      rddata;
    logic             rddvld;
    logic             waitreq;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_data;

    ncsi_fc_req_sched #(
        .MAX_FC_REQ (N),
        .HSSI_ADDR_W(16),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .fc_ctrl_i            (fc_ctrl),
        .fc_pend_i            (fc_pend),
        .fc_done_pls_o        (done),
        .fc_rsp_data_o        (rsp_data),
        .fc_rsp_code_o        (rsp_code),
        .fc_rsp_slot_o        (rsp_slot),
        .fc_busy_o            (busy),
        .hssi_avmm_m_addr_o   (addr),
        .hssi_avmm_m_write_o  (wr),
        .hssi_avmm_m_read_o   (rd),
        .hssi_avmm_m_wrdata_o (wrdata),
        .hssi_avmm_m_rddata_i (rddata),
        .hssi_avmm_m_rddvld_i (rddvld),
        .hssi_avmm_m_waitreq_i(waitreq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [15:0] pend;
        logic        op;
        logic [15:0] addr;
        logic [31:0] data;
        int          wait_n;
        int          rd_dly;
        logic [31:0] rdata;
        int          exp_slot;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        fc_pend = '0;
        rddvld  = 1'b0;
        waitreq = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b0;
    endtask

    // Entered at #1 after an edge with the DUT idle; cycle 0 is the grant cycle.
    task automatic run_vec(input int n, input vec_t v);
        int   strb_n, acc_cyc, done_cyc;
        logic addr_ok, type_ok, data_ok;
        logic [N-1:0] done_v;
        strb_n = 0; acc_cyc = -1; done_cyc = -1;
        addr_ok = 1'b1; type_ok = 1'b1; data_ok = 1'b1; done_v = '0;
        for (int i = 0; i < N; i++) begin
            fc_ctrl[64*i +: 64] = {15'd0, 1'b0, 16'hBAD0 + 16'(i), 32'hBAD0_0000 + 32'(i)};
        end
        fc_ctrl[64*v.exp_slot +: 64] = {15'd0, v.op, v.addr, v.data};
        fc_pend = v.pend;
        for (int cyc = 0; cyc < 64 && done_cyc < 0; cyc++) begin
            if (cyc > 0) next_cyc();
            rddvld = 1'b0;
            if (wr || rd) begin
                if (addr !== v.addr) addr_ok = 1'b0;
                if (wr !== v.op || rd !== !v.op) type_ok = 1'b0;
                if (v.op && wrdata !== v.data) data_ok = 1'b0;
                waitreq = (strb_n < v.wait_n);
                if (!waitreq) acc_cyc = cyc;
                strb_n++;
            end else begin
                waitreq = 1'b0;
            end
            if (!v.op && acc_cyc >= 0 && cyc == acc_cyc + v.rd_dly) begin
                rddvld = 1'b1;
                rddata = v.rdata;
            end
            if (cyc == 1) begin
                chk($sformatf("v%0d busy", n), 64'(busy), 64'd1);
                chk($sformatf("v%0d rsp_hold", n), 64'(rsp_data), 64'(last_data));
            end
            if (done != '0) begin
                done_cyc = cyc;
                done_v   = done;
                chk($sformatf("v%0d rsp_slot", n), 64'(rsp_slot), 64'(v.exp_slot));
                chk($sformatf("v%0d rsp_data", n), 64'(rsp_data), 64'(v.exp_data));
                chk($sformatf("v%0d rsp_code", n), 64'(rsp_code), 64'd0);
            end
        end
        chk($sformatf("v%0d latency", n), 64'(done_cyc), 64'(v.exp_lat));
        chk($sformatf("v%0d done_pls", n), 64'(done_v), 64'(1 << v.exp_slot));
        chk($sformatf("v%0d strobe_cycles", n), 64'(strb_n), 64'(v.wait_n + 1));
        chk($sformatf("v%0d addr_stable", n), 64'(addr_ok), 64'd1);
        chk($sformatf("v%0d strobe_type", n), 64'(type_ok), 64'd1);
        chk($sformatf("v%0d wrdata", n), 64'(data_ok), 64'd1);
        fc_pend   = '0;
        rddvld    = 1'b0;
        waitreq   = 1'b0;
        last_data = v.exp_data;
        next_cyc();
    endtask

    initial begin
        int   seen, pulses, idx;
        int   rr_slot[6];
        int   rr_cyc[6];
        int   exp_rr[6];
        logic [N-1:0] acc_done;

        vecs[0] = '{16'h0001, 1'b1, 16'h0040, 32'hA5A5_1234, 0, 0, 32'h0,         0, 32'h0,         2};
        vecs[1] = '{16'h0008, 1'b0, 16'h0100, 32'h0,         3, 5, 32'hDEAD_0003, 3, 32'hDEAD_0003, 10};
        vecs[2] = '{16'h0006, 1'b1, 16'h0011, 32'h1111_0001, 1, 0, 32'h0,         1, 32'h0,         3};
        vecs[3] = '{16'h0024, 1'b0, 16'h0222, 32'h0,         0, 1, 32'h2222_0002, 2, 32'h2222_0002, 3};
        vecs[4] = '{16'h8004, 1'b1, 16'hFFFC, 32'h0F0F_F0F0, 2, 0, 32'h0,         15, 32'h0,        4};
        vecs[5] = '{16'h0100, 1'b0, 16'h0808, 32'h0,         0, 2, 32'h8888_8888, 8, 32'h8888_8888, 4};
        vecs[6] = '{16'hFFFF, 1'b1, 16'h0909, 32'h9999_0009, 0, 0, 32'h0,         9, 32'h0,         2};
        exp_rr  = '{0, 1, 15, 0, 1, 15};

        fc_ctrl = '0;
        rddata  = '0;
        last_data = '0;
        do_reset();

        // Reset state
        chk("rst_outputs",
            64'({done, rsp_data, rsp_code, rsp_slot, busy, addr, wr, rd, wrdata}), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Round-robin wrap with pend held constant: 0, 1, 15, 0, 1, 15 every 3 cycles
        do_reset();
        for (int i = 0; i < N; i++) fc_ctrl[64*i +: 64] = {15'd0, 1'b1, 16'(i), 32'(i)};
        fc_pend = 16'h8003;
        seen = 0;
        for (int cyc = 0; cyc < 40 && seen < 6; cyc++) begin
            if (cyc > 0) next_cyc();
            if (done != '0) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (done[i]) idx = i;
                rr_slot[seen] = idx;
                rr_cyc[seen]  = cyc;
                seen++;
            end
        end
        fc_pend = '0;
        chk("rr_count", 64'(seen), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_slot%0d", i), 64'(rr_slot[i]), 64'(exp_rr[i]));
            chk($sformatf("rr_cyc%0d", i), 64'(rr_cyc[i]), 64'(2 + 3 * i));
        end
        next_cyc();

        // Reset mid-read, late rddvld ignored, fresh grant afterwards
        do_reset();
        fc_ctrl[63:0] = {15'd0, 1'b0, 16'h0030, 32'h0};
        fc_pend = 16'h0001;
        acc_done = '0;
        next_cyc();                                  // ISSUE, accepted
        chk("mid_issue_rd", 64'(rd), 64'd1);
        next_cyc();                                  // WAIT_RD: reset with response
        reset  = 1'b1;
        rddvld = 1'b1;
        rddata = 32'h1234_5678;
        chk("mid_rst_rd_drop", 64'(rd), 64'd0);
        acc_done |= done;
        next_cyc();                                  // IDLE after reset
        reset  = 1'b0;
        chk("mid_post_outputs",
            64'({done, rsp_data, rsp_code, rsp_slot, busy, addr, wr, rd, wrdata}), 64'd0);
        acc_done |= done;
        next_cyc();                                  // new ISSUE
        rddvld = 1'b0;
        chk("mid_regrant_rd", 64'(rd), 64'd1);
        chk("mid_late_rddvld", 64'(rsp_data), 64'd0);
        acc_done |= done;
        next_cyc();                                  // WAIT_RD
        rddvld = 1'b1;
        rddata = 32'h5555_AAAA;
        acc_done |= done;
        chk("mid_no_pulse", 64'(acc_done), 64'd0);
        next_cyc();                                  // DONE
        rddvld  = 1'b0;
        fc_pend = '0;
        chk("mid_done", 64'(done), 64'd1);
        chk("mid_data", 64'(rsp_data), 64'h5555_AAAA);
        next_cyc();

`ifdef NCSI_FC_TIMEOUT_EN
        // Timeout with no response, then a stray response at cycle 20
        fc_ctrl[63:0] = {15'd0, 1'b0, 16'h0044, 32'h0};
        fc_pend = 16'h0001;
        pulses = 0; idx = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) next_cyc();
            rddvld = (cyc == 20);
            rddata = 32'hBEEF_0020;
            if (done != '0) begin
                pulses++;
                if (idx < 0) begin
                    idx = cyc;
                    chk("tmo_code", 64'(rsp_code), 64'd1);
                    chk("tmo_data", 64'(rsp_data), 64'd0);
                end
                fc_pend = '0;
            end
        end
        rddvld = 1'b0;
        chk("tmo_cycle", 64'(idx), 64'd16);
        chk("tmo_pulses", 64'(pulses), 64'd1);
        chk("tmo_hold", 64'({rsp_code, rsp_data}), {30'd0, 2'b01, 32'd0});
        next_cyc();

        // Response in the expiry cycle wins
        fc_pend = 16'h0001;
        idx = -1;
        for (int cyc = 0; cyc < 30 && idx < 0; cyc++) begin
            if (cyc > 0) next_cyc();
            rddvld = (cyc == 15);
            rddata = 32'hC0DE_0015;
            if (done != '0) begin
                idx = cyc;
                chk("sim_code", 64'(rsp_code), 64'd0);
                chk("sim_data", 64'(rsp_data), 64'hC0DE_0015);
            end
        end
        fc_pend = '0;
        rddvld  = 1'b0;
        chk("sim_cycle", 64'(idx), 64'd16);
        next_cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
